k2_processor_param: RTL
=======================

# k2_processor_param

Parametrised next-generation K2 single-cycle accumulator core. It fetches one 8-bit instruction per accepted cycle from an external asynchronous program ROM addressed by `ProgramAddress`, and executes on registers RA/RB/RO with an add/sub ALU and carry/zero flags. It adds four things to the base K2 core:
- a configurable data width and program-counter width;
- a fetch-valid handshake;
- a HALT instruction;
- an `out_valid` strobe on every RO write.

## Interface
- `DATA_W`, default 8: datapath width (RA, RB, RO, data memory words); minimum 4.
- `PC_W`, default 4: program counter width; minimum 3.
- `MEM_DEPTH`, default 8: data memory words, addressed by imm; fixed at 8.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instruction_data` in 8: instruction at `ProgramAddress`, valid in the same cycle.
- `instr_valid` in 1: `instruction_data` is valid; the core stalls while low.
- `ProgramAddress` out PC_W: current PC.
- `Ro` out DATA_W: output register.
- `out_valid` out 1: one-cycle pulse, registered; high in the cycle after RO is written.
- `halted` out 1: core has executed HALT.

## Operation
- **Fields:** J=[7], C=[6], D=[5:4], S=[3], imm=[2:0]. imm is zero-extended to DATA_W for data and to PC_W for jumps.
- **J=0, C=0, D=00/01:** destination is RA (00) or RB (01).
  - S=0: destination <= imm.
  - S=1: destination <= ALU result, and CF/ZF are updated.
- **J=0, C=0, D=10:** RO <= RA, and `out_valid` is set next cycle.
- **J=0, C=0, D=11 (data memory):**
  - S=0: mem[imm] <= RA.
  - S=1: RA <= mem[imm].
  - Flags are unchanged.
- **J=0, C=1:** HALT.
- **J=1, C=0:** PC <= imm.
- **J=1, C=1:** conditional jump.
  - S=0: jump if CF. S=1: jump if ZF.
  - If not taken: PC <= PC+1.
  - D bits are ignored.
- **ALU:** imm[2]=0 computes RA+RB; imm[2]=1 computes RA+~RB+1.
  - CF is the carry out of bit DATA_W-1; for subtraction, CF=1 means no borrow.
  - ZF=1 iff result[DATA_W-1:0]==0.
  - imm[1:0] are ignored for ALU ops.
- **Conditional jumps** test the flag values registered before the jump instruction.
- **FSM with two states:**
  - RUN: accept an instruction when `instr_valid`=1.
  - HALT: entered on HALT; exited only by reset.
  - In HALT, PC, registers, flags and memory are frozen, `halted`=1 and `out_valid`=0.

## Timing
- **Reset (asynchronous, immediate):**
  - `ProgramAddress`=0, `Ro`=0, `out_valid`=0, `halted`=0.
  - RA, RB, CF, ZF and all memory words are 0.
  - State is RUN.
- **Accepted cycle:** `instr_valid`=1 in state RUN. All register, flag, memory and PC updates happen on that rising edge.
  - Execution latency is 1 cycle per instruction.
  - A value written by one instruction is visible to the next.
- **Non-jump, non-HALT instructions:** PC <= PC+1. The PC wraps from 2^PC_W-1 to 0.
- **Stall:** with `instr_valid`=0, nothing changes and `out_valid` is 0 the next cycle. Stalls may last any number of cycles.
- **HALT:** on the HALT edge, `halted` goes to 1 and PC holds at the HALT address. Later instructions are ignored regardless of `instr_valid`.
- **Load followed by store to the same address:** returns the previously stored value.
- **Memory read:** combinational. The memory write and the RA load take effect at the same edge.
- **Reset mid-stall or mid-HALT:** returns to RUN at PC 0.

## Configuration
- `K2P_DMEM_EN` defined: the 8 x DATA_W data memory is built and D=11 behaves as above.
- `K2P_DMEM_EN` undefined: no memory storage exists.
  - D=11 with J=0, C=0 is a NOP; PC still increments.
  - Registers and flags are unchanged.

## Test plan
- **Reset and immediate load:** reset, then 0x05 (RA<=5), 0x16 (RB<=6), 0x20 (RO<=RA).
  - `Ro`=5, with `out_valid` high exactly 1 cycle.
  - `ProgramAddress` steps 0,1,2,3.
- **ALU and flags (DATA_W=8):** RA=5, RB=5.
  - 0x0C (RA<=RA-RB) gives RA=0, ZF=1, CF=1.
  - Then 0xC9 (jump-if-ZF to 1): PC becomes 1.
  - With RA=0xFF, RB=1, 0x08 gives RA=0, CF=1.
- **Not-taken jump:** CF=0, then 0xC3. PC increments by 1 instead of loading 3.
- **Stall:** hold `instr_valid`=0 for 5 cycles mid-program.
  - PC, `Ro` and flags are unchanged and `out_valid`=0.
  - Execution resumes identically.
- **HALT and reset:** 0x40 at PC=4.
  - `halted`=1 and PC stays 4 for 10 cycles.
  - Asserting `rst_n`=0 mid-cycle clears `halted` and PC immediately.
- **Memory (with `K2P_DMEM_EN`):** RA=7; 0x32 (mem[2]<=RA); 0x00 (RA<=0); 0x3A (RA<=mem[2]); 0x20 (RO<=RA).
  - `Ro`=7.
  - Without the macro, `Ro`=0 and PC still advances.
- **Wrap-around (PC_W=4):** 16 consecutive NOP-class instructions. PC returns to 0.

Source files
------------

// File: rtl/k2_processor_param_if.sv
// k2_processor_param_if
//   Bundles the fetch and output signals of the K2 accumulator core so that
//   they travel as one port.
//   master : the core. It takes the instruction, drives the fetch address and
//            reports the output register and its status.
//   slave  : the program ROM / host side, which sees the same signals with
//            the directions reversed.
//   Signals:
//     instruction_data [7:0]   instruction at ProgramAddress, valid this cycle
//     instr_valid              instruction_data is valid (core stalls if low)
//     ProgramAddress [PC_W-1:0] current program counter
//     Ro [DATA_W-1:0]          output register
//     out_valid                one-cycle pulse after each RO write
//     halted                   core has executed HALT
interface k2_processor_param_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4
);
  logic [7:0]        instruction_data;
  logic              instr_valid;
  logic [PC_W-1:0]   ProgramAddress;
  logic [DATA_W-1:0] Ro;
  logic              out_valid;
  logic              halted;

  modport master (
    input  instruction_data,
    input  instr_valid,
    output ProgramAddress,
    output Ro,
    output out_valid,
    output halted
  );

  modport slave (
    output instruction_data,
    output instr_valid,
    input  ProgramAddress,
    input  Ro,
    input  out_valid,
    input  halted
  );
endinterface

// File: rtl/k2_processor_param.sv
// k2_processor_param
//   Single-cycle K2 accumulator core with parametrised data and PC widths.
//   It executes one 8-bit instruction per cycle in which instr_valid is high,
//   using registers RA/RB/RO, an add/sub ALU with carry and zero flags, and an
//   optional 8-word data memory. A HALT instruction freezes the core until
//   reset.
//   Parameters:
//     DATA_W    datapath width (>= 4)
//     PC_W      program counter width (>= 3)
//     MEM_DEPTH data memory words (fixed at 8, addressed by imm)
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    k2_processor_param_if.master (fetch, RO, out_valid, halted)
//   Build option:
//     K2P_DMEM_EN  when defined, the data memory exists and D=11 does
//                  load/store; otherwise D=11 is a NOP that only advances PC.
module k2_processor_param #(
  parameter int DATA_W    = 8,
  parameter int PC_W      = 4,
  parameter int MEM_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  k2_processor_param_if.master       bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic [DATA_W-1:0] ro_q, ro_d;
  logic              cf_q, cf_d;
  logic              zf_q, zf_d;
  logic              out_valid_q, out_valid_d;

  // Instruction fields
  logic       op_j, op_c, op_s;
  logic [1:0] op_d;
  logic [2:0] op_imm;

  assign op_j   = bus.instruction_data[7];
  assign op_c   = bus.instruction_data[6];
  assign op_d   = bus.instruction_data[5:4];
  assign op_s   = bus.instruction_data[3];
  assign op_imm = bus.instruction_data[2:0];

  logic [DATA_W-1:0] imm_data;
  logic [PC_W-1:0]   imm_pc;
  logic [PC_W-1:0]   pc_inc;

  assign imm_data = DATA_W'(op_imm);
  assign imm_pc   = PC_W'(op_imm);
  assign pc_inc   = pc_q + 1'b1;   // natural wrap at 2^PC_W

  // ALU: imm[2] selects subtraction as RA + ~RB + 1, so the carry out is the
  // "no borrow" indication.
  logic              alu_sub;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              alu_zero;

  assign alu_sub   = op_imm[2];
  assign alu_sum   = {1'b0, ra_q} + {1'b0, (alu_sub ? ~rb_q : rb_q)} + (DATA_W + 1)'(alu_sub);
  assign alu_res   = alu_sum[DATA_W-1:0];
  assign alu_carry = alu_sum[DATA_W];
  assign alu_zero  = (alu_res == '0);

`ifdef K2P_DMEM_EN
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_rd;
  logic              mem_we;

  // Combinational read so a load completes in the same cycle.
  assign mem_rd = mem_q[op_imm];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[op_imm] <= ra_q;
    end
  end
`endif

  logic [DATA_W-1:0] dest_val;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    ro_d        = ro_q;
    cf_d        = cf_q;
    zf_d        = zf_q;
    out_valid_d = 1'b0;
    dest_val    = imm_data;
`ifdef K2P_DMEM_EN
    mem_we      = 1'b0;
`endif

    // HALT is a sink state: nothing is accepted there until reset.
    if (state_q == ST_RUN && bus.instr_valid) begin
      pc_d = pc_inc;
      if (op_j) begin
        // Conditional jumps look at the flags as registered before this
        // instruction; D bits are don't-care.
        if (!op_c || (op_s ? zf_q : cf_q)) begin
          pc_d = imm_pc;
        end
      end else if (op_c) begin
        state_d = ST_HALT;
        pc_d    = pc_q;
      end else begin
        case (op_d)
          2'b00, 2'b01: begin
            if (op_s) begin
              dest_val = alu_res;
              cf_d     = alu_carry;
              zf_d     = alu_zero;
            end
            if (op_d[0]) begin
              rb_d = dest_val;
            end else begin
              ra_d = dest_val;
            end
          end
          2'b10: begin
            ro_d        = ra_q;
            out_valid_d = 1'b1;
          end
          default: begin
`ifdef K2P_DMEM_EN
            if (op_s) begin
              ra_d = mem_rd;
            end else begin
              mem_we = 1'b1;
            end
`endif
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      ro_q        <= '0;
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      ro_q        <= ro_d;
      cf_q        <= cf_d;
      zf_q        <= zf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.ProgramAddress = pc_q;
  assign bus.Ro             = ro_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.halted         = (state_q == ST_HALT);

endmodule
